// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter: FSM state encoding and
// latency-counter sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD_I = 2'd1,
        ARB_RD_D = 2'd2
    } arb_state_e;

    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter that times the memory read latency; parks at zero and
// flags it so the arbiter knows when read data is on m_rdata.
module arb_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the IFU fetch port and the MEM-stage data port onto one
// single-port memory, sequences its fixed read latency and drives the stall.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_ce,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wmask,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              stall
);

    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_lat_range
        $error("unified_mem_arbiter: MEM_LAT must be in 1..%0d", MEM_LAT_MAX);
    end

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              last_d_q;
    logic              last_d_d;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q;
    logic [DATA_W-1:0] d_rdata_d;

    logic active;
    logic in_idle;
    logic pick_d;
    logic rd_load;
    logic cnt_zero;

    // The async reset level also masks the combinational outputs so that
    // nothing leaks out while reset is held, regardless of the request inputs.
    assign active  = rst;
    assign in_idle = (state_q == ARB_IDLE);
    assign pick_d  = d_req & (~if_req | ~last_d_q);
    assign d_gnt   = active & in_idle & pick_d;
    assign if_gnt  = active & in_idle & if_req & ~pick_d;
    assign rd_load = if_gnt | (d_gnt & ~d_we);

    arb_lat_counter u_lat_counter (
        .clk      (clk),
        .rst_n    (rst),
        .load     (rd_load),
        .load_val (LAT_LOAD),
        .zero     (cnt_zero)
    );

    assign if_rvalid = (state_q == ARB_RD_I) & cnt_zero;
    assign d_rvalid  = (state_q == ARB_RD_D) & cnt_zero;
    assign if_rdata  = if_rvalid ? m_rdata : if_rdata_q;
    assign d_rdata   = d_rvalid  ? m_rdata : d_rdata_q;
    assign stall     = active & ((if_req & ~if_gnt) | (d_req & ~d_gnt) | ~in_idle);

    always_comb begin
        m_ce    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wmask = '0;
        if (d_gnt) begin
            m_ce   = 1'b1;
            m_we   = d_we;
            m_addr = d_addr;
            if (d_we) begin
                m_wdata = d_wdata;
                m_wmask = d_wmask;
            end
        end else if (if_gnt) begin
            m_ce   = 1'b1;
            m_addr = if_addr;
        end
    end

    // Data writes complete in their grant cycle, so only reads leave IDLE.
    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (if_gnt) begin
                    state_d = ARB_RD_I;
                end else if (d_gnt && !d_we) begin
                    state_d = ARB_RD_D;
                end
            end
            ARB_RD_I, ARB_RD_D: begin
                if (cnt_zero) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (d_gnt) begin
            last_d_d = 1'b1;
        end else if (if_gnt) begin
            last_d_d = 1'b0;
        end
        if (if_rvalid) begin
            if_rdata_d = m_rdata;
        end
        if (d_rvalid) begin
            d_rdata_d = m_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            last_d_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: a byte-maskable memory model with
// fixed read latency, and per-port queues of expected read data.
module tb_unified_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [3:0]    d_wmask = '0;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_ce;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wmask;
    logic [DW-1:0] m_rdata;
    logic          stall;

    int errors = 0;
    int checks = 0;

    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] rd_pipe[LAT];
    logic [31:0] i_exp;
    logic [31:0] d_exp;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MEM_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .m_ce      (m_ce),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wmask   (m_wmask),
        .m_rdata   (m_rdata),
        .stall     (stall)
    );

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    // Memory model: masked writes land at the edge, reads return LAT cycles after m_ce.
    always @(posedge clk) begin
        logic [31:0] w;
        if (m_ce && m_we) begin
            w = rd_word(m_addr);
            for (int b = 0; b < 4; b++) begin
                if (m_wmask[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
            end
            mem[m_addr] = w;
        end
        rd_pipe[0] <= (m_ce && !m_we) ? rd_word(m_addr) : 32'h0BAD_0BAD;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign m_rdata = rd_pipe[LAT-1];

    // Scoreboard: every read-data pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (if_rvalid) begin
            checks++;
            if (iq.size() == 0) begin
                errors++;
                $display("[TB] FAIL if_rvalid_unexpected: got if_rvalid=1 rdata=%h required no pulse", if_rdata);
            end else begin
                i_exp = iq.pop_front();
                if (if_rdata !== i_exp) begin
                    errors++;
                    $display("[TB] FAIL if_rdata: got %h required %h", if_rdata, i_exp);
                end
            end
        end
        if (d_rvalid) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("[TB] FAIL d_rvalid_unexpected: got d_rvalid=1 rdata=%h required no pulse", d_rdata);
            end else begin
                d_exp = dq.pop_front();
                if (d_rdata !== d_exp) begin
                    errors++;
                    $display("[TB] FAIL d_rdata: got %h required %h", d_rdata, d_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if_req  = 1'($urandom);
            if_addr = $urandom;
            d_req   = 1'($urandom);
            d_we    = 1'($urandom);
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wmask = 4'($urandom);
            @(negedge clk);
            checks++;
            if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, m_ce, m_we,
                 m_addr, m_wdata, m_wmask, stall} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_outputs: got gnt=%b%b rv=%b%b m_ce=%b m_addr=%h stall=%b required all 0",
                         if_gnt, d_gnt, if_rvalid, d_rvalid, m_ce, m_addr, stall);
            end
        end
        tick();
        if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall, if_gnt, d_gnt, m_ce} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL release_idle: got stall=%b gnt=%b%b m_ce=%b required 0000", stall, if_gnt, d_gnt, m_ce);
        end
    endtask

    task automatic test_fetch_read();
        tick();
        if_req = 1; if_addr = 32'h0040_0000;
        iq.push_back(32'h2408_0001);
        @(negedge clk);
        checks++;
        if ({if_gnt, d_gnt, m_ce, m_we, m_wmask} !== 8'b1010_0000 || m_addr !== 32'h0040_0000) begin
            errors++;
            $display("[TB] FAIL fetch_grant: got gnt=%b%b ce=%b we=%b mask=%b addr=%h required 10 1 0 0000 00400000",
                     if_gnt, d_gnt, m_ce, m_we, m_wmask, m_addr);
        end
        tick();
        if_req = 0;
        @(negedge clk);
        checks++;
        if ({m_ce, if_rvalid, stall} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL fetch_t1: got ce=%b rvalid=%b stall=%b required 0 0 1", m_ce, if_rvalid, stall);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({if_rvalid, stall} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL fetch_t2: got rvalid=%b stall=%b required 1 1", if_rvalid, stall);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({if_rvalid, stall} !== 2'b00 || if_rdata !== 32'h2408_0001) begin
            errors++;
            $display("[TB] FAIL fetch_t3: got rvalid=%b stall=%b rdata=%h required 0 0 24080001",
                     if_rvalid, stall, if_rdata);
        end
    endtask

    task automatic test_arbitration();
        tick();
        if_req = 1; if_addr = 32'h0040_0004;
        d_req = 1; d_we = 0; d_addr = 32'h1001_0004;
        dq.push_back(32'h0000_1234);
        iq.push_back(32'h8C09_0000);
        @(negedge clk);
        checks++;
        if ({d_gnt, if_gnt, stall} !== 3'b011 && {d_gnt, if_gnt, stall} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL arb_first: got d_gnt=%b if_gnt=%b stall=%b required 1 0 1", d_gnt, if_gnt, stall);
        end else if (d_gnt !== 1'b1 || stall !== 1'b1 || m_addr !== 32'h1001_0004) begin
            errors++;
            $display("[TB] FAIL arb_first: got d_gnt=%b stall=%b addr=%h required 1 1 10010004", d_gnt, stall, m_addr);
        end
        tick();
        d_req = 0;
        @(negedge clk);
        checks++;
        if ({d_gnt, if_gnt, stall} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL arb_t1: got d_gnt=%b if_gnt=%b stall=%b required 0 0 1", d_gnt, if_gnt, stall);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({d_rvalid, if_gnt} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL arb_t2: got d_rvalid=%b if_gnt=%b required 1 0", d_rvalid, if_gnt);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({if_gnt, d_rvalid} !== 2'b10 || m_addr !== 32'h0040_0004) begin
            errors++;
            $display("[TB] FAIL arb_t3: got if_gnt=%b d_rvalid=%b addr=%h required 1 0 00400004", if_gnt, d_rvalid, m_addr);
        end
        tick();
        if_req = 0;
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arb_t4: got if_rvalid=%b required 0", if_rvalid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arb_t5: got if_rvalid=%b required 1", if_rvalid);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({if_rvalid, stall} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL arb_t6: got if_rvalid=%b stall=%b required 0 0", if_rvalid, stall);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1;
        logic [31:0] w2;
        w1 = 32'hA1A1_0001;
        w2 = 32'hB2B2_0002;
        for (int c = 0; c <= 8; c++) begin
            tick();
            d_req   = (c <= 4);
            d_we    = 1;
            d_addr  = (c == 0) ? 32'h1001_0008 : 32'h1001_000C;
            d_wdata = (c == 0) ? w1 : w2;
            d_wmask = 4'hF;
            if_req  = (c <= 5);
            if_addr = (c <= 1) ? 32'h0040_0008 : 32'h0040_000C;
            if (c == 0) iq.push_back(32'h0000_0013);
            if (c == 2) iq.push_back(32'h2129_FFFF);
            @(negedge clk);
            checks++;
            if ({d_gnt, if_gnt} !== {(c == 0 || c == 4), (c == 1 || c == 5)} ||
                if_rvalid !== (c == 3 || c == 7)) begin
                errors++;
                $display("[TB] FAIL b2b_cycle%0d: got d_gnt=%b if_gnt=%b if_rvalid=%b required %b %b %b", c,
                         d_gnt, if_gnt, if_rvalid, (c == 0 || c == 4), (c == 1 || c == 5), (c == 3 || c == 7));
            end
            if (c == 0 || c == 4) begin
                checks++;
                if ({m_ce, m_we, m_wmask} !== 6'b11_1111 || m_wdata !== ((c == 0) ? w1 : w2)) begin
                    errors++;
                    $display("[TB] FAIL b2b_write%0d: got ce=%b we=%b mask=%b wdata=%h required 1 1 1111 %h", c,
                             m_ce, m_we, m_wmask, m_wdata, (c == 0) ? w1 : w2);
                end
            end
        end
    endtask

    task automatic test_write();
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h1001_0000; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
        @(negedge clk);
        checks++;
        if ({d_gnt, m_ce, m_we, m_wmask, stall} !== 8'b1110_0110 || m_wdata !== 32'hDEAD_BEEF ||
            m_addr !== 32'h1001_0000) begin
            errors++;
            $display("[TB] FAIL write_grant: got gnt=%b ce=%b we=%b mask=%b stall=%b wdata=%h addr=%h required 1 1 1 0011 0 deadbeef 10010000",
                     d_gnt, m_ce, m_we, m_wmask, stall, m_wdata, m_addr);
        end
        tick();
        d_req = 0; d_we = 0; d_wdata = '0; d_wmask = '0;
        @(negedge clk);
        checks++;
        if ({m_ce, m_we, stall, d_rvalid} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL write_after: got ce=%b we=%b stall=%b d_rvalid=%b required 0000", m_ce, m_we, stall, d_rvalid);
        end
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h1001_0000;
        dq.push_back(32'h1122_BEEF);
        @(negedge clk);
        checks++;
        if ({d_gnt, d_rvalid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL write_readback_gnt: got d_gnt=%b d_rvalid=%b required 1 0", d_gnt, d_rvalid);
        end
        tick();
        d_req = 0;
        tick();
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_readback_rvalid: got %b required 1", d_rvalid);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h1001_0004;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_gnt: got d_gnt=%b required 1", d_gnt);
        end
        tick();
        d_req = 0;
        rst = 0;
        @(negedge clk);
        checks++;
        if ({d_rvalid, stall, d_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_in_reset: got d_rvalid=%b stall=%b d_rdata=%h required 0 0 0", d_rvalid, stall, d_rdata);
        end
        tick();
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({d_rvalid, stall} !== 2'b00 || d_rdata !== 32'h0) begin
                errors++;
                $display("[TB] FAIL midrst_after%0d: got d_rvalid=%b stall=%b d_rdata=%h required 0 0 0", i,
                         d_rvalid, stall, d_rdata);
            end
            tick();
        end
        d_req = 1; d_we = 0; d_addr = 32'h1001_0004;
        dq.push_back(32'h0000_1234);
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_new_gnt: got d_gnt=%b required 1", d_gnt);
        end
        tick();
        d_req = 0;
        tick();
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_new_rvalid: got d_rvalid=%b required 1", d_rvalid);
        end
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        mem[32'h0040_0000] = 32'h2408_0001;
        mem[32'h0040_0004] = 32'h8C09_0000;
        mem[32'h0040_0008] = 32'h0000_0013;
        mem[32'h0040_000C] = 32'h2129_FFFF;
        mem[32'h1001_0000] = 32'h1122_3344;
        mem[32'h1001_0004] = 32'h0000_1234;

        test_reset();
        test_fetch_read();
        test_arbitration();
        test_back_to_back();
        test_write();
        test_reset_mid_read();

        checks++;
        if (iq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_reads: got iq=%0d dq=%0d outstanding required 0 0", iq.size(), dq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
